// File: rtl/dcache_write_buffer_if.sv
// ----------------------------------------------------------------------------
// dcache_write_buffer_if
// Handshake bundle between the DCache write port, the write buffer and the
// AXI bridge's DCache write interface.
//   in_wr_*  : DCache -> buffer push channel (req/rdy + line/store fields)
//   out_wr_* : buffer -> bridge drain channel (req/rdy + head entry fields)
// Modports:
//   slave  : the write buffer (accepts in_wr_*, drives out_wr_*)
//   master : the environment (DCache side and bridge side together)
// ----------------------------------------------------------------------------
interface dcache_write_buffer_if;
    logic         in_wr_req;
    logic [2:0]   in_wr_type;
    logic [31:0]  in_wr_addr;
    logic [3:0]   in_wr_wstrb;
    logic [127:0] in_wr_data;
    logic         in_wr_rdy;

    logic         out_wr_req;
    logic [2:0]   out_wr_type;
    logic [31:0]  out_wr_addr;
    logic [3:0]   out_wr_wstrb;
    logic [127:0] out_wr_data;
    logic         out_wr_rdy;

    modport slave (
        input  in_wr_req, in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data,
        output in_wr_rdy,
        output out_wr_req, out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data,
        input  out_wr_rdy
    );

    modport master (
        output in_wr_req, in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data,
        input  in_wr_rdy,
        input  out_wr_req, out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data,
        output out_wr_rdy
    );
endinterface

// File: rtl/dcache_write_buffer.sv
// ----------------------------------------------------------------------------
// dcache_write_buffer
// In-order write-back buffer between the DCache write port and the AXI
// bridge. Queues line writebacks and uncached stores so a refill need not
// wait for its dirty victim, and flags reads that hit a queued line.
//
// Ports:
//   aclk, reset     : clock, synchronous active-high reset
//   bus (slave)     : in_wr_* push channel, out_wr_* drain channel
//   rd_chk_addr     : address of the DCache read about to issue
//   rd_hit          : a held entry matches rd_chk_addr[31:4]
//   rd_fwd_valid/_data : line forwarding result (WB_FORWARD_EN only)
//   wb_empty        : no entries held
//
// Build option: define WB_FORWARD_EN to forward the youngest matching line
// entry's data; otherwise rd_fwd_* are tied to 0.
// ----------------------------------------------------------------------------
module dcache_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                      aclk,
    input  logic                      reset,
    dcache_write_buffer_if.slave      bus,
    input  logic [31:0]               rd_chk_addr,
    output logic                      rd_hit,
    output logic                      rd_fwd_valid,
    output logic [127:0]              rd_fwd_data,
    output logic                      wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [2:0]   r_type  [DEPTH];
    logic [31:0]  r_addr  [DEPTH];
    logic [3:0]   r_wstrb [DEPTH];
    logic [127:0] r_data  [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;

    logic w_full, w_empty, w_push, w_pop;
    logic [DEPTH-1:0] w_match;
    logic [3:0] w_unused_lo;

    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

    // No same-cycle bypass: a full buffer refuses even while popping.
    assign bus.in_wr_rdy  = ~w_full & ~reset;
    assign bus.out_wr_req = ~w_empty;
    assign w_push = bus.in_wr_req & bus.in_wr_rdy;
    assign w_pop  = bus.out_wr_req & bus.out_wr_rdy;

    assign bus.out_wr_type  = r_type[r_rptr];
    assign bus.out_wr_addr  = r_addr[r_rptr];
    assign bus.out_wr_wstrb = r_wstrb[r_rptr];
    assign bus.out_wr_data  = r_data[r_rptr];
    assign wb_empty         = w_empty;

    // Byte offset within the line never matters for the hazard compare.
    assign w_unused_lo = rd_chk_addr[3:0];

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i]  <= '0;
                r_addr[i]  <= '0;
                r_wstrb[i] <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            // A push never targets the popped slot: push needs ~full, pop needs ~empty.
            if (w_push) begin
                r_type[r_wptr]  <= bus.in_wr_type;
                r_addr[r_wptr]  <= bus.in_wr_addr;
                r_wstrb[r_wptr] <= bus.in_wr_wstrb;
                r_data[r_wptr]  <= bus.in_wr_data;
                r_vld[r_wptr]   <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Hazard covers stored entries only (incl. one popping this cycle).
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_match[i] = r_vld[i] & (r_addr[i][31:4] == rd_chk_addr[31:4]);
    end
    assign rd_hit = |w_match;

`ifdef WB_FORWARD_EN
    logic          w_fwd_line;
    logic [127:0]  w_fwd_data;
    logic [PW-1:0] w_idx;

    // Walk oldest to youngest from the read pointer; the last match wins,
    // so the youngest matching entry decides. Valid entries are contiguous.
    always_comb begin
        w_fwd_line = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + PW'(k);
            if (w_match[w_idx]) begin
                w_fwd_line = (r_type[w_idx] == 3'b100);
                w_fwd_data = r_data[w_idx];
            end
        end
    end
    assign rd_fwd_valid = w_fwd_line;
    assign rd_fwd_data  = w_fwd_line ? w_fwd_data : '0;
`else
    assign rd_fwd_valid = 1'b0;
    assign rd_fwd_data  = '0;
`endif
endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Write-back buffer between the DCache write port and the AXI bridge's DCache write interface. It queues line writebacks and uncached stores so a DCache miss can refill without waiting for its dirty victim to drain. It also reports read-after-write hazards for queued entries. Entries drain in order through the same single-cycle req/rdy handshake the bridge exposes.

## Interface
- `DEPTH`, default 2: number of buffered entries; power of two, 2..8.
- `aclk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `in_wr_req` in 1: DCache write request.
- `in_wr_type` in 3: 3'b100 = 4-beat line; 3'b000/001/010 = single byte/half/word.
- `in_wr_addr` in 32: byte address.
- `in_wr_wstrb` in 4: byte strobes for single-beat writes; ignored (stored) for lines.
- `in_wr_data` in 128: line data; word 0 in bits [31:0].
- `in_wr_rdy` out 1: buffer can accept this cycle.
- `out_wr_req` out 1: head entry valid, toward bridge.
- `out_wr_type` out 3, `out_wr_addr` out 32, `out_wr_wstrb` out 4, `out_wr_data` out 128: head entry fields.
- `out_wr_rdy` in 1: bridge ready; pop on `out_wr_req & out_wr_rdy`.
- `rd_chk_addr` in 32: address of the DCache read about to be issued.
- `rd_hit` out 1: some queued entry matches `rd_chk_addr[31:4]`.
- `rd_fwd_valid` out 1, `rd_fwd_data` out 128: forwarding result (only with `WB_FORWARD_EN`).
- `wb_empty` out 1: no entries held; used by the pipeline for uncached/fence ordering.

## Operation
- Circular FIFO of `DEPTH` entries {type, addr, wstrb, data}.
  - Write pointer and read pointer are each `log2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Occupancy count is `log2(DEPTH)+1` bits.
- Push:
  - `in_wr_rdy = ~full & ~reset`.
  - Push occurs on `in_wr_req & in_wr_rdy`.
  - All input fields are captured in that cycle; the DCache may change them afterwards.
- Pop:
  - `out_wr_req = ~empty`.
  - All `out_wr_*` fields come directly from the head entry registers.
  - Pop occurs on `out_wr_req & out_wr_rdy`; the next entry, if any, is presented the following cycle.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - When full, `in_wr_rdy` is 0 even if a pop happens this cycle (no same-cycle bypass).
- Ordering: strictly FIFO; entries are never merged or reordered.
- Hazard check:
  - `rd_hit` is combinational over stored valid entries only.
  - An entry being pushed this cycle is not checked.
  - An entry being popped this cycle is still checked.
  - Comparison is always on the line address `[31:4]`, for both line and single-beat entries.
  - The DCache holds its read request while `rd_hit` is 1.
- Each entry's `type` and `wstrb` are passed to the bridge unmodified.

## Timing
- Reset values: pointers 0, count 0, all entry valid bits 0.
  - Outputs during and after reset: `out_wr_req` 0, `in_wr_rdy` 0 during reset and 1 the cycle after, `rd_hit` 0, `rd_fwd_valid` 0, `wb_empty` 1, `out_wr_*` data fields 0.
- Push-to-`out_wr_req` latency when empty: 1 cycle (registered).
- Back-to-back pops: with `out_wr_rdy` held high, one entry drains per cycle. The bridge itself deasserts `out_wr_rdy` until its B response, so sustained throughput is bounded by the bridge.
- Reset mid-operation: all queued entries are discarded. Any partially sent bridge transaction is not this block's concern.
- `wb_empty` is 1 exactly when count is 0; it rises in the cycle after the last pop.
- `rd_hit` and `rd_fwd_*` have zero-cycle latency from `rd_chk_addr` and the current state.

## Configuration
- Macro `WB_FORWARD_EN`.
- Defined:
  - Search priority is youngest to oldest among entries matching `rd_chk_addr[31:4]`.
  - If the youngest match has type 3'b100: `rd_fwd_valid` = 1 and `rd_fwd_data` = that entry's data. The DCache uses it as refill data and skips the bridge read.
  - If the youngest match is single-beat: `rd_fwd_valid` = 0 and `rd_hit` = 1 (stall).
- Undefined:
  - `rd_fwd_valid` is tied 0 and `rd_fwd_data` is tied 0.
  - No priority logic is built; `rd_hit` alone stalls the read.

## Test plan
- Reset, then push a line with addr 0x1C00_0040, data {4{32'hA5A5_0000}}, `out_wr_rdy` = 0 → `out_wr_req` = 1 next cycle with identical fields; `wb_empty` = 0; `rd_hit` = 1 for `rd_chk_addr` 0x1C00_004C and 0 for 0x1C00_0050.
- `DEPTH` = 2, push 3 entries back-to-back with `out_wr_rdy` = 0 → `in_wr_rdy` = 0 after the 2nd push and the 3rd is held; raise `out_wr_rdy` for 1 cycle → the 3rd is accepted the cycle after the pop.
- Full buffer, then assert push and pop in the same cycle → the pop completes, the push is refused, count = 1.
- Push a word store (addr 0x0000_1004, wstrb 4'b0011) then a line (addr 0x0000_1000) → drain order is the store first, then the line; `out_wr_wstrb` is 4'b0011 on the first.
  - With `WB_FORWARD_EN`: `rd_chk_addr` 0x0000_1008 gives `rd_fwd_valid` = 1 with the line's data.
- With `WB_FORWARD_EN`, push a line then a word store to the same line → `rd_hit` = 1, `rd_fwd_valid` = 0.
- Push 2 entries, assert `reset` for 1 cycle → `out_wr_req` = 0, `wb_empty` = 1, `rd_hit` = 0; the pointers wrap correctly over 10 subsequent push/pop pairs.
